// File: rtl/yolov4_layer_ctrl_if.sv
// Command, parameter-stream, buffer-load and engine handshake bundle for the layer sequencer.
interface yolov4_layer_ctrl_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DATA_W = 64
);
  logic              start;
  logic [1:0]        layer_type;
  logic [CNT_W-1:0]  scale_len;
  logic [CNT_W-1:0]  weight_len;
  logic [CNT_W-1:0]  bias_len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ld_we;
  logic [1:0]        ld_sel;
  logic [CNT_W-1:0]  ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              op_start;
  logic [1:0]        op_sel;
  logic              op_done;
  logic              busy;
  logic              done;
  logic [3:0]        state;

  // Host/DMA and engine side
  modport master (
    output start, layer_type, scale_len, weight_len, bias_len, in_valid, in_data, op_done,
    input  in_ready, ld_we, ld_sel, ld_addr, ld_data, op_start, op_sel, busy, done, state
  );

  // Sequencer side
  modport slave (
    input  start, layer_type, scale_len, weight_len, bias_len, in_valid, in_data, op_done,
    output in_ready, ld_we, ld_sel, ld_addr, ld_data, op_start, op_sel, busy, done, state
  );
endinterface

// File: rtl/yolov4_layer_ctrl.sv
// Per-layer sequencer: latches a command, streams scale/weight/bias words into the
// parameter buffers (conv only), then launches the selected engine and waits for it.
module yolov4_layer_ctrl #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DATA_W = 64
) (
  input logic              clk,
  input logic              rstn,
  yolov4_layer_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE           = 4'd0,
    RECEIVE_SCALE  = 4'd1,
    RECEIVE_WEIGHT = 4'd2,
    RECEIVE_BIAS   = 4'd3,
    CONV_STATE     = 4'd4,
    MAX_POOL_STATE = 4'd5,
    UPSAMPLE_STATE = 4'd6,
    ROUTE_STATE    = 4'd7
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        type_q, type_d;
  logic [CNT_W-1:0]  scale_len_q, scale_len_d;
  logic [CNT_W-1:0]  weight_len_q, weight_len_d;
  logic [CNT_W-1:0]  bias_len_q, bias_len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_start_q, op_start_d;
  logic              done_q, done_d;

  logic              rx_phase;
  logic [CNT_W-1:0]  cur_len;
  logic [1:0]        sel_c;
  logic              in_ready_c;
  logic              beat;
  logic              phase_end;
  logic              is_op_q, is_op_d;
  logic [DATA_W-1:0] data_c;

  // Registered state, latched command fields, word counter and pulse outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      type_q       <= '0;
      scale_len_q  <= '0;
      weight_len_q <= '0;
      bias_len_q   <= '0;
      cnt_q        <= '0;
      op_start_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      scale_len_q  <= scale_len_d;
      weight_len_q <= weight_len_d;
      bias_len_q   <= bias_len_d;
      cnt_q        <= cnt_d;
      op_start_q   <= op_start_d;
      done_q       <= done_d;
    end
  end

  // Next-state, counter and beat decode
  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    scale_len_d  = scale_len_q;
    weight_len_d = weight_len_q;
    bias_len_d   = bias_len_q;
    cnt_d        = cnt_q;
    rx_phase     = 1'b0;
    cur_len      = '0;
    sel_c        = 2'd0;

    case (state_q)
      RECEIVE_SCALE:  begin rx_phase = 1'b1; cur_len = scale_len_q;  sel_c = 2'd1; end
      RECEIVE_WEIGHT: begin rx_phase = 1'b1; cur_len = weight_len_q; sel_c = 2'd2; end
      RECEIVE_BIAS:   begin rx_phase = 1'b1; cur_len = bias_len_q;   sel_c = 2'd3; end
      default:        ;
    endcase

    // An empty phase still spends one cycle with the stream closed
    in_ready_c = rx_phase && (cur_len != '0);
    beat       = in_ready_c && bus.in_valid;
    phase_end  = (cur_len == '0) || (beat && (cnt_q == cur_len - CNT_W'(1)));

    if (rx_phase) begin
      if (phase_end)  cnt_d = '0;
      else if (beat)  cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          type_d       = bus.layer_type;
          scale_len_d  = bus.scale_len;
          weight_len_d = bus.weight_len;
          bias_len_d   = bus.bias_len;
          case (bus.layer_type)
            2'd0:    state_d = RECEIVE_SCALE;
            2'd1:    state_d = MAX_POOL_STATE;
            2'd2:    state_d = UPSAMPLE_STATE;
            default: state_d = ROUTE_STATE;
          endcase
        end
      end
      RECEIVE_SCALE:  if (phase_end) state_d = RECEIVE_WEIGHT;
      RECEIVE_WEIGHT: if (phase_end) state_d = RECEIVE_BIAS;
      RECEIVE_BIAS:   if (phase_end) state_d = CONV_STATE;
      CONV_STATE, MAX_POOL_STATE, UPSAMPLE_STATE, ROUTE_STATE: begin
        if (bus.op_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Launch pulse on entry to an op state; done pulse on the op-state exit
    is_op_q    = (state_q == CONV_STATE) || (state_q == MAX_POOL_STATE) ||
                 (state_q == UPSAMPLE_STATE) || (state_q == ROUTE_STATE);
    is_op_d    = (state_d == CONV_STATE) || (state_d == MAX_POOL_STATE) ||
                 (state_d == UPSAMPLE_STATE) || (state_d == ROUTE_STATE);
    op_start_d = is_op_d && !is_op_q;
    done_d     = is_op_q && bus.op_done;
    data_c     = beat ? bus.in_data : '0;
  end

  // Buffer writes follow the accepted beat in the same cycle
  assign bus.in_ready = in_ready_c;
  assign bus.ld_we    = beat;
  assign bus.ld_sel   = sel_c;
  assign bus.ld_addr  = beat ? cnt_q : '0;
  assign bus.ld_data  = data_c;
  assign bus.op_start = op_start_q;
  assign bus.op_sel   = type_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_yolov4_layer_ctrl.sv
// Directed bench for the layer sequencer with a buffer-write scoreboard.
module tb_yolov4_layer_ctrl;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         sbq[$];
  logic [15:0] mlen [0:3];
  logic [15:0] mcnt;
  logic [3:0]  prev_es;
  logic [1:0]  mtype;
  logic [15:0] sl, wl, bl;

  yolov4_layer_ctrl_if #(.CNT_W(16), .DATA_W(64)) bus ();

  yolov4_layer_ctrl #(.CNT_W(16), .DATA_W(64)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Synchronous reset for one edge, then check the all-zero output state
  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.op_done = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    sbq.delete();
    mcnt = 16'd0; prev_es = 4'd0; mtype = 2'd0;
    for (int i = 0; i < 4; i++) mlen[i] = 16'd0;
    #1;
    chk("rst_state",    64'(bus.state),    64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_ld_we",    64'(bus.ld_we),    64'd0);
    chk("rst_op_start", 64'(bus.op_start), 64'd0);
    chk("rst_busy",     64'(bus.busy),     64'd0);
    chk("rst_done",     64'(bus.done),     64'd0);
    chk("rst_ld_sel",   64'(bus.ld_sel),   64'd0);
    chk("rst_ld_addr",  64'(bus.ld_addr),  64'd0);
    chk("rst_op_sel",   64'(bus.op_sel),   64'd0);
  endtask

  // One cycle: drive inputs, model expected beat, check outputs of this cycle
  task automatic cyc(input logic st, input logic [1:0] lt, input logic vld, input logic od,
                     input logic [3:0] es, input logic eos, input logic ed);
    wr_t         w;
    logic [63:0] d;
    logic [1:0]  esel;
    logic        erdy;
    @(posedge clk); #1;
    d = {$urandom, $urandom};
    bus.start = st; bus.layer_type = lt; bus.in_valid = vld; bus.in_data = d;
    bus.op_done = od; bus.scale_len = sl; bus.weight_len = wl; bus.bias_len = bl;
    if (es != prev_es) mcnt = 16'd0;
    prev_es = es;
    esel = (es >= 4'd1 && es <= 4'd3) ? es[1:0] : 2'd0;
    erdy = (esel != 2'd0) && (mlen[esel] != 16'd0);
    if (vld && erdy) begin
      sbq.push_back('{esel, mcnt, d});
      mcnt = mcnt + 16'd1;
    end
    if (st && es == 4'd0) begin
      mlen[1] = sl; mlen[2] = wl; mlen[3] = bl; mtype = lt;
    end
    #1;
    chk("state",    64'(bus.state),    64'(es));
    chk("busy",     64'(bus.busy),     64'(es != 4'd0));
    chk("done",     64'(bus.done),     64'(ed));
    chk("op_start", 64'(bus.op_start), 64'(eos));
    chk("ld_sel",   64'(bus.ld_sel),   64'(esel));
    chk("in_ready", 64'(bus.in_ready), 64'(erdy));
    if (es >= 4'd4 && es <= 4'd7) chk("op_sel", 64'(bus.op_sel), 64'(mtype));
    if (sbq.size() > 0) begin
      w = sbq.pop_front();
      chk("ld_we",   64'(bus.ld_we),   64'd1);
      chk("ld_sel_w", 64'(bus.ld_sel), 64'(w.sel));
      chk("ld_addr", 64'(bus.ld_addr), 64'(w.addr));
      chk("ld_data", bus.ld_data,      w.data);
    end else begin
      chk("ld_we_idle", 64'(bus.ld_we), 64'd0);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rstn = 1'b0;
    bus.start = 1'b0; bus.layer_type = 2'd0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.op_done = 1'b0; bus.scale_len = '0; bus.weight_len = '0; bus.bias_len = '0;
    sl = 16'd0; wl = 16'd0; bl = 16'd0;
    do_reset();

    // Full conv 2/3/1, in_valid held high, op_done at cycle 12
    sl = 16'd2; wl = 16'd3; bl = 16'd1;
    cyc(1, 2'd0, 0, 0, 4'd0, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd1, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 2'd0, 1, 0, 4'd2, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd3, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd4, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 2'd0, 1, 0, 4'd4, 0, 0);
    cyc(0, 2'd0, 1, 1, 4'd4, 0, 0);
    // Max-pool started on the done cycle
    cyc(1, 2'd1, 0, 0, 4'd0, 0, 1);
    cyc(0, 2'd0, 1, 0, 4'd5, 1, 0);
    cyc(0, 2'd0, 1, 0, 4'd5, 0, 0);
    cyc(0, 2'd0, 0, 1, 4'd5, 0, 0);
    cyc(0, 2'd0, 0, 0, 4'd0, 0, 1);

    // Backpressure in weight phase, illegal start in bias, op_done with op_start, op_done in IDLE
    sl = 16'd1; wl = 16'd3; bl = 16'd2;
    cyc(1, 2'd0, 0, 0, 4'd0, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd1, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd2, 0, 0);
    cyc(0, 2'd0, 0, 0, 4'd2, 0, 0);
    cyc(0, 2'd0, 0, 0, 4'd2, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd2, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd2, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd3, 0, 0);
    sl = 16'd7; wl = 16'd7; bl = 16'd5;
    cyc(1, 2'd3, 0, 0, 4'd3, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd3, 0, 0);
    cyc(0, 2'd0, 0, 1, 4'd4, 1, 0);
    cyc(0, 2'd0, 0, 1, 4'd0, 0, 1);
    cyc(0, 2'd0, 0, 0, 4'd0, 0, 0);

    // Zero-length weight phase
    sl = 16'd1; wl = 16'd0; bl = 16'd1;
    cyc(1, 2'd0, 0, 0, 4'd0, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd1, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd2, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd3, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd4, 1, 0);
    cyc(0, 2'd0, 0, 1, 4'd4, 0, 0);
    cyc(0, 2'd0, 0, 0, 4'd0, 0, 1);

    // Reset on cycle 4 of the weight phase, then a minimal conv restarts at address 0
    sl = 16'd1; wl = 16'd6; bl = 16'd1;
    cyc(1, 2'd0, 0, 0, 4'd0, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 2'd0, 1, 0, 4'd2, 0, 0);
    do_reset();
    cyc(0, 2'd0, 0, 0, 4'd0, 0, 0);
    sl = 16'd1; wl = 16'd1; bl = 16'd1;
    cyc(1, 2'd0, 1, 0, 4'd0, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd1, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd2, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd3, 0, 0);
    cyc(0, 2'd0, 1, 1, 4'd4, 1, 0);
    cyc(0, 2'd0, 0, 0, 4'd0, 0, 1);

    // Upsample and route commands
    cyc(1, 2'd2, 0, 0, 4'd0, 0, 0);
    cyc(0, 2'd0, 1, 0, 4'd6, 1, 0);
    cyc(0, 2'd0, 0, 1, 4'd6, 0, 0);
    cyc(0, 2'd0, 0, 0, 4'd0, 0, 1);
    cyc(1, 2'd3, 0, 0, 4'd0, 0, 0);
    cyc(0, 2'd0, 0, 1, 4'd7, 1, 0);
    cyc(0, 2'd0, 0, 0, 4'd0, 0, 1);
    cyc(0, 2'd0, 0, 0, 4'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
